// File: rtl/exp_align_scheduler.sv
// exp_align_scheduler
//   Time-multiplexed exponent-alignment controller for the dot-product FMA front end.
//   Collects NUM_TERMS serial a/b exponent pairs (plus the addend exponent on the last
//   beat), tracks the running maximum product exponent, computes the addend shift and
//   result exponent in one CALC cycle, then streams one product shift per handshake.
//
//   Optional feature: define SHAMT_SAT_EN to saturate shamt_ab/shamt_c at
//   2^SHAMT_WIDTH-1 instead of truncating modulo 2^SHAMT_WIDTH.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               synchronous abort back to IDLE, highest priority
//   in_valid/in_ready   term beat handshake; aExp, bExp per beat
//   cExp, cIsSubnormal  addend exponent/subnormal flag, sampled on the final beat
//   out_valid/out_ready shift beat handshake; out_idx, out_last, shamt_ab per beat
//   shamt_c, exp1       addend shift and result exponent, held from CALC until next CALC
//   busy                high whenever not IDLE
module exp_align_scheduler #(
  parameter int unsigned EXP_WIDTH   = 8,
  parameter int unsigned SIG_WIDTH   = 23,
  parameter int unsigned BIAS        = 127,
  parameter int unsigned SHAMT_WIDTH = 8,
  parameter int unsigned NUM_TERMS   = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_WIDTH-1:0]   aExp,
  input  logic [EXP_WIDTH-1:0]   bExp,
  input  logic [EXP_WIDTH-1:0]   cExp,
  input  logic                   cIsSubnormal,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_idx,
  output logic                   out_last,
  output logic [SHAMT_WIDTH-1:0] shamt_ab,
  output logic [SHAMT_WIDTH-1:0] shamt_c,
  output logic [EXP_WIDTH-1:0]   exp1,
  output logic                   busy
);

  localparam int unsigned PW = EXP_WIDTH + 1;  // product exponent width
  localparam int unsigned CW = EXP_WIDTH + 3;  // signed CALC arithmetic width

  localparam logic signed [CW-1:0] BiasC   = CW'(BIAS);
  localparam logic signed [CW-1:0] OffC    = CW'(SIG_WIDTH + 7);
  localparam logic [3:0]           LastIdx = 4'(NUM_TERMS - 1);

`ifdef SHAMT_SAT_EN
  localparam logic [31:0] MaxShamt = 32'((64'd1 << SHAMT_WIDTH) - 64'd1);
`endif

  typedef enum logic [1:0] {StIdle, StCollect, StCalc, StEmit} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             count_q, count_d;
  logic [3:0]             idx_q, idx_d;
  logic [PW-1:0]          exp_pro_q, exp_pro_d;
  logic [PW-1:0]          prod_q [NUM_TERMS];
  logic [PW-1:0]          prod_d [NUM_TERMS];
  logic [EXP_WIDTH-1:0]   c_exp_q, c_exp_d;
  logic                   c_sub_q, c_sub_d;
  logic [SHAMT_WIDTH-1:0] shamt_c_q, shamt_c_d;
  logic [EXP_WIDTH-1:0]   exp1_q, exp1_d;

  function automatic logic [SHAMT_WIDTH-1:0] fit_shamt(input logic [31:0] v);
`ifdef SHAMT_SAT_EN
    if (v > MaxShamt) return '1;
    return SHAMT_WIDTH'(v);
`else
    return SHAMT_WIDTH'(v);
`endif
  endfunction

  // CALC datapath, evaluated from registered exp_pro and latched addend.
  logic [PW-1:0]        prod_beat;
  logic signed [CW-1:0] exp_pro_s, unb_s, t_s, c_s, shamt_i;
  logic [31:0]          shamt_c_full, diff_ab;

  assign prod_beat    = PW'(aExp) + PW'(bExp);
  assign exp_pro_s    = $signed({2'b00, exp_pro_q});
  assign unb_s        = exp_pro_s - BiasC;
  assign t_s          = unb_s + OffC;
  assign c_s          = $signed({3'b000, c_exp_q});
  assign shamt_i      = (c_s > t_s) ? '0 : (t_s - c_s);
  assign shamt_c_full = 32'($unsigned(shamt_i)) + 32'(c_sub_q);
  // exp_pro is the maximum, so this difference is never negative.
  assign diff_ab      = 32'(exp_pro_q) - 32'(prod_q[idx_q]);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    exp_pro_d = exp_pro_q;
    prod_d    = prod_q;
    c_exp_d   = c_exp_q;
    c_sub_d   = c_sub_q;
    shamt_c_d = shamt_c_q;
    exp1_d    = exp1_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          prod_d[0] = prod_beat;
          exp_pro_d = prod_beat;
          count_d   = 4'd1;
          state_d   = StCollect;
        end
      end
      StCollect: begin
        in_ready = 1'b1;
        if (in_valid) begin
          prod_d[count_q] = prod_beat;
          // Strict compare: ties keep the earlier maximum.
          if (prod_beat > exp_pro_q) exp_pro_d = prod_beat;
          count_d = count_q + 4'd1;
          if (count_q == LastIdx) begin
            c_exp_d = cExp;
            c_sub_d = cIsSubnormal;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        shamt_c_d = fit_shamt(shamt_c_full);
        exp1_d    = EXP_WIDTH'(unb_s);
        idx_d     = 4'd0;
        state_d   = StEmit;
      end
      StEmit: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (idx_q == LastIdx) begin
            idx_d   = 4'd0;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over everything; any beat this cycle is dropped, results are kept.
    if (flush) begin
      state_d   = StIdle;
      count_d   = 4'd0;
      idx_d     = 4'd0;
      exp_pro_d = exp_pro_q;
      prod_d    = prod_q;
      c_exp_d   = c_exp_q;
      c_sub_d   = c_sub_q;
      shamt_c_d = shamt_c_q;
      exp1_d    = exp1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      count_q   <= 4'd0;
      idx_q     <= 4'd0;
      exp_pro_q <= '0;
      for (int i = 0; i < NUM_TERMS; i++) prod_q[i] <= '0;
      c_exp_q   <= '0;
      c_sub_q   <= 1'b0;
      shamt_c_q <= '0;
      exp1_q    <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      exp_pro_q <= exp_pro_d;
      prod_q    <= prod_d;
      c_exp_q   <= c_exp_d;
      c_sub_q   <= c_sub_d;
      shamt_c_q <= shamt_c_d;
      exp1_q    <= exp1_d;
    end
  end

  assign out_idx  = idx_q;
  assign out_last = (state_q == StEmit) && (idx_q == LastIdx);
  assign shamt_ab = (state_q == StEmit) ? fit_shamt(diff_ab) : '0;
  assign shamt_c  = shamt_c_q;
  assign exp1     = exp1_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: doc/exp_align_scheduler.md
Name: exp_align_scheduler

Overview:
- Time-multiplexed exponent-alignment controller for the 9-term dot-product FMA front end.
- Collects NUM_TERMS serial a/b exponent pairs plus the addend exponent, and tracks the running maximum product exponent.
- Computes the addend shift and result exponent, then streams out one product shift amount per handshake to the serial alignment shifter.
- Replaces the parallel 9-way comparison tree when area matters more than latency.

Parameters:
- EXP_WIDTH, 8, exponent field width.
- SIG_WIDTH, 23, significand width; the addend offset is SIG_WIDTH+7.
- BIAS, 127, exponent bias.
- SHAMT_WIDTH, 8, shift-amount width.
- NUM_TERMS, 9, products per operation (2..16).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; returns to IDLE.
- in_valid  in  1  term beat valid.
- in_ready  out  1  term beat accepted when in_valid&&in_ready.
- aExp  in  EXP_WIDTH  multiplicand exponent.
- bExp  in  EXP_WIDTH  multiplier exponent.
- cExp  in  EXP_WIDTH  addend exponent, sampled on the final term beat.
- cIsSubnormal  in  1  addend subnormal flag, sampled with cExp.
- out_valid  out  1  shift beat valid.
- out_ready  in  1  downstream accepts the shift beat.
- out_idx  out  4  term index of the current shamt_ab.
- out_last  out  1  marks the final shift beat.
- shamt_ab  out  SHAMT_WIDTH  product alignment shift.
- shamt_c  out  SHAMT_WIDTH  addend shift, stable from CALC until IDLE.
- exp1  out  EXP_WIDTH  result exponent, exp_pro-BIAS truncated.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - All outputs 0, except in_ready=1.
  - Term count, exp_pro and the product register file cleared.
- States: IDLE, COLLECT, CALC, EMIT.
- IDLE:
  - in_ready=1.
  - An accepted beat stores prod[0]=aExp+bExp (EXP_WIDTH+1 bits, no overflow), sets exp_pro=prod[0], count=1, and moves to COLLECT.
- COLLECT:
  - in_ready=1.
  - Each accepted beat stores prod[count], updates exp_pro=max(exp_pro,prod) using an unsigned compare, and increments count.
  - The beat with count==NUM_TERMS-1 also latches cExp/cIsSubnormal and moves to CALC.
  - Gaps (in_valid low) hold state.
- CALC (exactly 1 cycle, in_ready=0), computed in EXP_WIDTH+3-bit signed arithmetic:
  - t = exp_pro - BIAS + (SIG_WIDTH+7).
  - shamt_i = (cExp > t) ? 0 : t - cExp.
  - shamt_c = shamt_i + cIsSubnormal, truncated to SHAMT_WIDTH.
  - exp1 = (exp_pro - BIAS) truncated to EXP_WIDTH.
  - Then go to EMIT with idx=0.
- EMIT:
  - in_ready=0, out_valid=1.
  - shamt_ab = exp_pro - prod[idx], truncated to SHAMT_WIDTH.
  - out_idx=idx; out_last=(idx==NUM_TERMS-1).
  - On out_valid&&out_ready, idx increments.
  - On the last handshake: out_valid drops the next cycle, state goes to IDLE, shamt_c/exp1 keep their value until the next CALC.
  - With out_ready low, all outputs hold stable.
- Throughput and latency:
  - One operation = NUM_TERMS input beats + 1 CALC cycle + NUM_TERMS output beats.
  - First out_valid comes 2 cycles after the final input beat.
  - No overlap between operations.
- flush:
  - Has priority over every other event in the same cycle.
  - Next state is IDLE, and any input beat in that cycle is dropped.
  - out_valid/out_last cleared; shamt_c/exp1 retained.
- Equal maxima: ties keep the earlier value; the result is identical either way.

Optional Feature:
- Macro: SHAMT_SAT_EN.
- Defined: shamt_ab and shamt_c saturate to 2^SHAMT_WIDTH-1 whenever the true difference exceeds it.
- Undefined: plain truncation to SHAMT_WIDTH bits, modulo 2^SHAMT_WIDTH.

Test Plan:
- 9 beats aExp=bExp=127, cExp=127, out_ready=1:
  - all shamt_ab=0, shamt_c=30, exp1=127.
  - out_last on idx 8; first out_valid 2 cycles after beat 9.
- Beats 0-7 aExp=bExp=127, beat 8 aExp=bExp=130, cExp=127:
  - shamt_ab idx0-7=6, idx8=0, exp1=133, shamt_c=36.
- Same products, cExp=200 -> shamt_c=0; cExp=0 with cIsSubnormal=1 -> shamt_c=164.
- Beat 0 aExp=bExp=0, beats 1-8 aExp=bExp=254:
  - idx0 shamt_ab=252 without SHAMT_SAT_EN, 255 with it.
  - other shamt_ab=0.
- Toggle out_ready 0/1 randomly in EMIT -> outputs held while stalled, no lost or duplicated idx, exactly 9 handshakes.
- flush asserted after beat 4, then a fresh 9-beat operation -> the new result ignores pre-flush beats.
- rst_n pulsed low mid-EMIT -> all outputs 0 and in_ready=1 immediately, without waiting for a clock edge.
